// File: rtl/mem_pointer.sv
// SRP16 memory-pointer register: loadable from the data bus, drives the address bus
// with the pointer (post-increment by a signed offset) or pointer+offset, and the data bus with the pointer.
module mem_pointer #(
    parameter int WIDTH        = 16,
    parameter int OFFSET_WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        din,
    input  logic [OFFSET_WIDTH-1:0] offsetin,
    input  logic                    read_abus,
    input  logic                    read_abusplus,
    input  logic                    read_dbus,
    input  logic                    write,
    input  logic                    writeu,
    output logic [WIDTH-1:0]        abus_out,
    output logic [WIDTH-1:0]        dbus_out
);

    localparam int HALF = WIDTH / 2;

    logic [WIDTH-1:0] r_ptr;
    logic [WIDTH-1:0] w_off;
    logic [WIDTH-1:0] w_sum;

    assign w_off = {{(WIDTH-OFFSET_WIDTH){offsetin[OFFSET_WIDTH-1]}}, offsetin};
    assign w_sum = r_ptr + w_off;

    // Loads take precedence over the post-increment driven by read_abus.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (write) begin
            r_ptr <= din;
        end else if (writeu) begin
            r_ptr <= {din[HALF-1:0], r_ptr[HALF-1:0]};
        end else if (read_abus) begin
            r_ptr <= w_sum;
        end
    end

    assign abus_out = read_abus     ? r_ptr :
                      read_abusplus ? w_sum : 'z;
    assign dbus_out = read_dbus     ? r_ptr : 'z;

endmodule

// File: tb/tb_mem_pointer.sv
// Scoreboard bench for mem_pointer; undriven buses are pulled high so high-Z reads as 16'hFFFF.
module tb_mem_pointer;

    typedef struct {
        string       tag;
        logic        on_dbus;
        logic [15:0] exp;
    } sb_item_t;

    logic        clk;
    logic        run;
    logic        reset;
    logic [15:0] din;
    logic [11:0] offsetin;
    logic        read_abus;
    logic        read_abusplus;
    logic        read_dbus;
    logic        write;
    logic        writeu;
    tri1  [15:0] w_abus;
    tri1  [15:0] w_dbus;

    sb_item_t    sb_q[$];
    logic [15:0] m_ptr;
    int unsigned n_checks;
    int unsigned n_errors;

    mem_pointer #(.WIDTH(16), .OFFSET_WIDTH(12)) dut (
        .clk          (clk),
        .reset        (reset),
        .din          (din),
        .offsetin     (offsetin),
        .read_abus    (read_abus),
        .read_abusplus(read_abusplus),
        .read_dbus    (read_dbus),
        .write        (write),
        .writeu       (writeu),
        .abus_out     (w_abus),
        .dbus_out     (w_dbus)
    );

    always begin
        #5;
        if (run) clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %04h expected %04h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic on_dbus, input logic [15:0] exp);
        sb_item_t it;
        it.tag     = tag;
        it.on_dbus = on_dbus;
        it.exp     = exp;
        sb_q.push_back(it);
    endtask

    task automatic sb_drain();
        sb_item_t it;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            chk(it.tag, it.on_dbus ? w_dbus : w_abus, it.exp);
        end
    endtask

    function automatic logic [15:0] sext(input logic [11:0] o);
        return o[11] ? (16'hF000 | 16'(o)) : 16'(o);
    endfunction

    // One clock: drive on the falling edge, check the combinational buses, then let the edge update.
    task automatic cycle(input string tag, input logic w, input logic wu, input logic ra,
                         input logic rap, input logic rd, input logic [15:0] d, input logic [11:0] off);
        logic [15:0] e_abus;
        logic [15:0] e_dbus;
        @(negedge clk);
        write = w; writeu = wu; read_abus = ra; read_abusplus = rap; read_dbus = rd;
        din = d; offsetin = off;
        if (ra)       e_abus = m_ptr;
        else if (rap) e_abus = m_ptr + sext(off);
        else          e_abus = 16'hFFFF;
        e_dbus = rd ? m_ptr : 16'hFFFF;
        sb_push({tag, "_abus"}, 1'b0, e_abus);
        sb_push({tag, "_dbus"}, 1'b1, e_dbus);
        #1;
        sb_drain();
        @(posedge clk);
        if (reset) begin
            if (w)       m_ptr = d;
            else if (wu) m_ptr = {d[7:0], m_ptr[7:0]};
            else if (ra) m_ptr = m_ptr + sext(off);
        end
    endtask

    task automatic peek(input string tag, input logic [15:0] exp);
        @(negedge clk);
        write = 0; writeu = 0; read_abus = 0; read_abusplus = 0; read_dbus = 1;
        sb_push(tag, 1'b1, exp);
        #1;
        sb_drain();
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        clk = 0; run = 0;
        reset = 0; din = '0; offsetin = '0;
        write = 0; writeu = 0; read_abus = 0; read_abusplus = 0; read_dbus = 1;
        m_ptr = 16'h0000;
        #2;
        sb_push("rst_ptr", 1'b1, 16'h0000);
        sb_push("rst_abus_z", 1'b0, 16'hFFFF);
        #1;
        sb_drain();
        read_dbus = 0;
        #1;
        sb_push("idle_abus_z", 1'b0, 16'hFFFF);
        sb_push("idle_dbus_z", 1'b1, 16'hFFFF);
        sb_drain();
        reset = 1;
        #1;
        run = 1;

        cycle("wr0F0F", 1, 0, 0, 0, 0, 16'h0F0F, 12'h000);
        peek("p0F0F", 16'h0F0F);
        cycle("inc2a", 0, 0, 1, 0, 0, 16'h0000, 12'h002);
        cycle("inc2b", 0, 0, 1, 0, 0, 16'h0000, 12'h002);
        peek("p0F13", 16'h0F13);
        cycle("inc4a", 0, 0, 1, 0, 0, 16'h0000, 12'h004);
        cycle("inc4b", 0, 0, 1, 0, 1, 16'h0000, 12'h004);
        peek("p0F1B", 16'h0F1B);
        cycle("wru", 0, 1, 0, 0, 0, 16'h0003, 12'h000);
        peek("p031B", 16'h031B);
        cycle("inc0a", 0, 0, 1, 0, 0, 16'h0000, 12'h000);
        cycle("inc0b", 0, 0, 1, 0, 0, 16'h0000, 12'h000);
        cycle("rd", 0, 0, 0, 0, 1, 16'h0000, 12'h000);
        cycle("rap0", 0, 0, 0, 1, 0, 16'h0000, 12'h000);
        peek("p031B_b", 16'h031B);

        cycle("wr0010", 1, 0, 0, 0, 0, 16'h0010, 12'h000);
        cycle("rapm2", 0, 0, 0, 1, 1, 16'h0000, 12'hFFE);
        peek("p0010", 16'h0010);
        cycle("incm2", 0, 0, 1, 0, 0, 16'h0000, 12'hFFE);
        peek("p000E", 16'h000E);
        cycle("wrFFFF", 1, 0, 0, 0, 0, 16'hFFFF, 12'h000);
        cycle("wrapup", 0, 0, 1, 0, 0, 16'h0000, 12'h001);
        peek("p0000", 16'h0000);
        cycle("wrapdn", 0, 0, 1, 0, 0, 16'h0000, 12'hFFF);
        peek("pFFFF", 16'hFFFF);

        cycle("wr1000", 1, 0, 0, 0, 0, 16'h1000, 12'h000);
        cycle("rapmax", 0, 0, 0, 1, 0, 16'h0000, 12'h7FF);
        cycle("rapmin", 0, 0, 0, 1, 0, 16'h0000, 12'h800);
        cycle("both", 0, 0, 1, 1, 0, 16'h0000, 12'h010);
        peek("p1010", 16'h1010);
        cycle("wr_wu", 1, 1, 0, 0, 0, 16'hBEEF, 12'h000);
        peek("pBEEF", 16'hBEEF);
        cycle("wu_inc", 0, 1, 1, 0, 0, 16'h0042, 12'h001);
        peek("p42EF", 16'h42EF);
        cycle("wr_inc", 1, 0, 1, 0, 1, 16'h1234, 12'h005);
        peek("p1234", 16'h1234);

        @(negedge clk);
        #2;
        reset = 0;
        m_ptr = 16'h0000;
        #1;
        sb_push("midrst", 1'b1, 16'h0000);
        sb_drain();
        write = 1; din = 16'hABCD;
        @(posedge clk);
        #1;
        sb_push("rst_block", 1'b1, 16'h0000);
        sb_drain();
        @(negedge clk);
        reset = 1;
        cycle("resume", 1, 0, 0, 0, 0, 16'h5A5A, 12'h000);
        peek("p5A5A", 16'h5A5A);

        for (int i = 0; i < 24; i++) begin
            cycle("rnd", 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  16'($urandom), 12'($urandom));
        end
        peek("rnd_end", m_ptr);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
